// File: rtl/apb_sweep_pkg.sv
// Shared types and defaults for the APB sin-sweep master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPACE,
        W_SETUP,
        W_ACCESS,
        R_SETUP,
        R_ACCESS
    } state_t;

    localparam logic [31:0] DEF_CTRL_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_OUT_ADDR  = 32'h0000_0004;

    // APB select is high for both phases of either transfer.
    function automatic logic is_selected(input state_t s);
        return (s == W_SETUP) || (s == W_ACCESS) || (s == R_SETUP) || (s == R_ACCESS);
    endfunction

    function automatic logic is_access(input state_t s);
        return (s == W_ACCESS) || (s == R_ACCESS);
    endfunction

endpackage

// File: rtl/apb_sin_sweep_master_sample_fifo.sv
// Sample buffer between the APB read path and the sample stream.
// Latency: push visible at head the cycle after the push edge (first-word-fall-through).
// Backpressure: full is reported to the writer; push while full is dropped unless a pop frees a slot.
//
// Ports: clk/rst (async, active-high), push/push_dat in, pop in, pop_dat (head) out,
//        full/empty/count status out.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a push needs when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_sin_sweep_master.sv
// APB master sweeping n over a range: write n to CTRL_ADDR, read OUT_ADDR, buffer result.
// Latency: start at c0 -> W_SETUP c1, R_ACCESS c4, smp_valid c5; 4 cycles/sample zero-wait.
// Backpressure: full sample buffer parks the FSM in SPACE; slow PREADY stretches ACCESS up to TIMEOUT.
//
// Ports: PCLK/PRESET (async, active-high); start/n_start/n_count control in;
//        busy/done/err status out; APB master PSEL..PWDATA out, PRDATA/PREADY in;
//        sample stream smp_valid/smp_data out, smp_ready in.
module apb_sin_sweep_master
    import apb_sweep_pkg::*;
#(
    parameter logic [31:0] CTRL_ADDR  = DEF_CTRL_ADDR,
    parameter logic [31:0] OUT_ADDR   = DEF_OUT_ADDR,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [31:0] n_start,
    input  logic [15:0] n_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [31:0] smp_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [31:0]   n_q, n_d;
    logic [15:0]   rem_q, rem_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          pwrite_q, pwrite_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic          space_after_push;
    logic          tmo_expired;
    logic          abort;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk      (PCLK),
        .rst      (PRESET),
        .push     (fifo_push),
        .push_dat (PRDATA),
        .pop      (fifo_pop),
        .pop_dat  (smp_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign fifo_pop  = smp_valid && smp_ready;
    assign smp_valid = !fifo_empty;

    // Occupancy after this cycle's push and any concurrent pop; decides whether
    // the next write may start immediately or must wait in SPACE.
    assign space_after_push = (fifo_cnt + CW'(1) - CW'(fifo_pop)) < CW'(FIFO_DEPTH);

    // This is the TIMEOUT-th PREADY-low cycle of the current ACCESS phase.
    assign tmo_expired = (tmo_q == TW'(TIMEOUT - 1));

    // Select/enable decode straight from the state flop so an async reset
    // drops them in the same cycle.
    assign PSEL    = is_selected(state_q);
    assign PENABLE = is_access(state_q);
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        rem_d     = rem_q;
        tmo_d     = tmo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        fifo_push = 1'b0;
        abort     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d   = n_start;
                    rem_d = n_count;
                    err_d = 1'b0;
                    if (n_count == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = fifo_full ? SPACE : W_SETUP;
                    end
                end
            end
            SPACE: begin
                if (!fifo_full) begin
                    state_d = W_SETUP;
                end
            end
            W_SETUP: begin
                state_d = W_ACCESS;
                tmo_d   = '0;
            end
            W_ACCESS: begin
                if (PREADY) begin
                    state_d = R_SETUP;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            R_SETUP: begin
                state_d = R_ACCESS;
                tmo_d   = '0;
            end
            R_ACCESS: begin
                if (PREADY) begin
                    fifo_push = 1'b1;
                    n_d       = n_q + 32'd1;
                    rem_d     = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = space_after_push ? W_SETUP : SPACE;
                    end
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort keeps whatever samples are already buffered.
        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end

        // Address-phase fields are loaded on entry to SETUP and then held,
        // which keeps them stable across ACCESS and while the bus is idle.
        if ((state_d == W_SETUP) && (state_q != W_SETUP)) begin
            paddr_d  = CTRL_ADDR;
            pwrite_d = 1'b1;
            pwdata_d = n_d;
        end
        if ((state_d == R_SETUP) && (state_q != R_SETUP)) begin
            paddr_d  = OUT_ADDR;
            pwrite_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            n_q      <= '0;
            rem_q    <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            rem_q    <= rem_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
        end
    end

endmodule

// File: tb/tb_apb_sin_sweep_master.sv
// Bench for apb_sin_sweep_master with an APB_sin-like slave model and sample consumer.
// Latency: n/a.
// Backpressure: consumer ready and slave wait states are driven per scenario.
module tb_apb_sin_sweep_master;

    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 4;

    logic        PCLK;
    logic        PRESET;
    logic        start;
    logic [31:0] n_start;
    logic [15:0] n_count;
    logic        busy, done, err;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY;
    logic        smp_valid, smp_ready;
    logic [31:0] smp_data;

    apb_sin_sweep_master #(
        .CTRL_ADDR  (32'h0),
        .OUT_ADDR   (32'h4),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .start     (start),
        .n_start   (n_start),
        .n_count   (n_count),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_data  (smp_data)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    // ---------------- slave model ----------------
    logic [31:0] ctrl_reg;
    int          acc_cnt;
    int          ws;
    logic        hang_en;
    logic [15:0] hang_n;

    assign PRDATA = {16'hA5A5, ctrl_reg[15:0]};
    assign PREADY = PSEL && PENABLE && (acc_cnt >= ws) &&
                    !(hang_en && !PWRITE && (ctrl_reg[15:0] == hang_n));

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_reg <= '0;
            acc_cnt  <= 0;
        end else begin
            if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
            else acc_cnt <= 0;
            if (PSEL && PENABLE && PREADY && PWRITE && (PADDR == 32'h0)) ctrl_reg <= PWDATA;
        end
    end

    // ---------------- monitor (mid-cycle) ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] dat;
        int          cyc;
    } xfer_t;

    xfer_t       xq[$];
    logic [31:0] sq[$];
    int ncyc = 0;
    int start_cyc = 0, first_psel_cyc = -1, first_valid_cyc = -1, done_cyc = 0;
    int done_cnt = 0, psel_cnt = 0, busy_seen = 0, run = 0, last_run = 0, stab_err = 0;
    int d0 = 0;
    logic [31:0] su_addr, su_wdata;
    logic        su_write;

    always @(negedge PCLK) begin
        ncyc++;
        if (start) start_cyc = ncyc;
        if (PSEL) begin
            psel_cnt++;
            if (first_psel_cyc < 0) first_psel_cyc = ncyc;
        end
        if (smp_valid && first_valid_cyc < 0) first_valid_cyc = ncyc;
        if (done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
        if (busy) busy_seen = 1;
        if (PENABLE && !PSEL) stab_err++;
        if (PSEL && !PENABLE) begin
            su_addr  = PADDR;
            su_wdata = PWDATA;
            su_write = PWRITE;
        end
        if (PSEL && PENABLE) begin
            run++;
            if (PADDR !== su_addr || PWRITE !== su_write || (su_write && PWDATA !== su_wdata))
                stab_err++;
            if (PREADY) xq.push_back(xfer_t'{PWRITE, PADDR, PWRITE ? PWDATA : PRDATA, ncyc});
        end else if (run > 0) begin
            last_run = run;
            run = 0;
        end
        if (smp_valid && smp_ready) sq.push_back(smp_data);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] smp_of(input logic [31:0] n);
        return {16'hA5A5, n[15:0]};
    endfunction

    // Expected i-th transfer of a sweep from base: even = write n, odd = read result.
    function automatic xfer_t exp_xfer(input logic [31:0] base, input int i);
        logic [31:0] n;
        n = base + 32'(i / 2);
        if (i % 2 == 0) return xfer_t'{1'b1, 32'h0, n, 0};
        return xfer_t'{1'b0, 32'h4, smp_of(n), 0};
    endfunction

    // ---------------- stimulus utilities ----------------
    task automatic kick(input logic [31:0] n, input logic [15:0] c);
        xq.delete();
        sq.delete();
        d0 = done_cnt;
        first_psel_cyc  = -1;
        first_valid_cyc = -1;
        psel_cnt  = 0;
        busy_seen = 0;
        stab_err  = 0;
        n_start = n;
        n_count = c;
        start   = 1'b1;
        @(posedge PCLK); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rnd_ready) smp_ready = 1'($urandom_range(0, 1));
            @(posedge PCLK); #1;
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain();
        smp_ready = 1'b1;
        repeat (8) @(posedge PCLK);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3;
        checks++;
        if ({PSEL, PENABLE, PWRITE, busy, done, err, smp_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000000", {PSEL, PENABLE, PWRITE, busy, done, err, smp_valid});
        end
        checks++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h wdata=%h want 0", PADDR, PWDATA);
        end
        checks++;
        if (smp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_smp got %h want 0", smp_data);
        end
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic test_basic();
        bit    ok;
        xfer_t e;
        ws = 0;
        smp_ready = 1'b1;
        kick(32'h0, 16'd10);
        wait_done(200, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done got timeout want done"); end
        drain();
        checks++;
        if (xq.size() != 20) begin errors++; $display("FAIL basic_nxfer got %0d want 20", xq.size()); end
        for (int i = 0; i < xq.size() && i < 20; i++) begin
            e = exp_xfer(32'h0, i);
            checks++;
            if (xq[i].wr !== e.wr || xq[i].addr !== e.addr || xq[i].dat !== e.dat) begin
                errors++;
                $display("FAIL basic_xfer[%0d] got wr=%0b addr=%h dat=%h want wr=%0b addr=%h dat=%h",
                         i, xq[i].wr, xq[i].addr, xq[i].dat, e.wr, e.addr, e.dat);
            end
            if (i > 0) begin
                checks++;
                if (xq[i].cyc - xq[i-1].cyc != 2) begin
                    errors++;
                    $display("FAIL basic_cadence[%0d] got %0d want 2", i, xq[i].cyc - xq[i-1].cyc);
                end
            end
        end
        checks++;
        if (first_psel_cyc != start_cyc + 1) begin
            errors++;
            $display("FAIL basic_wsetup_lat got %0d want %0d", first_psel_cyc - start_cyc, 1);
        end
        checks++;
        if (xq.size() < 2 || xq[1].cyc != start_cyc + 4) begin
            errors++;
            $display("FAIL basic_raccess_lat got %0d want 4", xq.size() < 2 ? -1 : xq[1].cyc - start_cyc);
        end
        checks++;
        if (first_valid_cyc != start_cyc + 5) begin
            errors++;
            $display("FAIL basic_valid_lat got %0d want 5", first_valid_cyc - start_cyc);
        end
        checks++;
        if (sq.size() != 10) begin errors++; $display("FAIL basic_nsmp got %0d want 10", sq.size()); end
        for (int i = 0; i < sq.size() && i < 10; i++) begin
            checks++;
            if (sq[i] !== smp_of(32'(i))) begin
                errors++;
                $display("FAIL basic_smp[%0d] got %h want %h", i, sq[i], smp_of(32'(i)));
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got done_pulses=%0d err=%b busy=%b want 1 0 0", done_cnt - d0, err, busy);
        end
    endtask

    task automatic test_zero_count();
        kick($urandom, 16'd0);
        repeat (4) @(posedge PCLK);
        #1;
        checks++;
        if (done_cnt - d0 != 1 || done_cyc != start_cyc + 1) begin
            errors++;
            $display("FAIL zero_done got pulses=%0d at +%0d want 1 at +1", done_cnt - d0, done_cyc - start_cyc);
        end
        checks++;
        if (busy_seen != 0 || psel_cnt != 0) begin
            errors++;
            $display("FAIL zero_quiet got busy_seen=%0d psel_cycles=%0d want 0 0", busy_seen, psel_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit          ok;
        logic [31:0] base;
        base = $urandom;
        ws = 0;
        smp_ready = 1'b0;
        kick(base, 16'd6);
        repeat (40) @(posedge PCLK);
        #1;
        checks++;
        if (xq.size() != 8 || sq.size() != 0) begin
            errors++;
            $display("FAIL bp_parked got xfers=%0d pops=%0d want 8 0", xq.size(), sq.size());
        end
        checks++;
        if (PSEL !== 1'b0 || busy !== 1'b1 || smp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_state got psel=%b busy=%b valid=%b want 0 1 1", PSEL, busy, smp_valid);
        end
        smp_ready = 1'b1;
        wait_done(100, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done got timeout want done"); end
        drain();
        checks++;
        if (sq.size() != 6) begin errors++; $display("FAIL bp_nsmp got %0d want 6", sq.size()); end
        for (int i = 0; i < sq.size() && i < 6; i++) begin
            checks++;
            if (sq[i] !== smp_of(base + 32'(i))) begin
                errors++;
                $display("FAIL bp_smp[%0d] got %h want %h", i, sq[i], smp_of(base + 32'(i)));
            end
        end
    endtask

    task automatic test_wait_states();
        bit          ok;
        logic [31:0] base;
        xfer_t       e;
        base = $urandom;
        ws = 3;
        smp_ready = 1'b1;
        kick(base, 16'd4);
        wait_done(200, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ws_done got timeout want done"); end
        drain();
        checks++;
        if (stab_err != 0) begin errors++; $display("FAIL ws_stable got %0d violations want 0", stab_err); end
        checks++;
        if (xq.size() != 8) begin errors++; $display("FAIL ws_nxfer got %0d want 8", xq.size()); end
        for (int i = 0; i < xq.size() && i < 8; i++) begin
            e = exp_xfer(base, i);
            checks++;
            if (xq[i].wr !== e.wr || xq[i].addr !== e.addr || xq[i].dat !== e.dat) begin
                errors++;
                $display("FAIL ws_xfer[%0d] got wr=%0b addr=%h dat=%h want wr=%0b addr=%h dat=%h",
                         i, xq[i].wr, xq[i].addr, xq[i].dat, e.wr, e.addr, e.dat);
            end
            if (i >= 3 && i % 2 == 1) begin
                checks++;
                if (xq[i].cyc - xq[i-2].cyc != 10) begin
                    errors++;
                    $display("FAIL ws_cadence[%0d] got %0d want 10", i, xq[i].cyc - xq[i-2].cyc);
                end
            end
        end
        ws = 0;
    endtask

    task automatic test_timeout();
        bit          ok;
        logic [31:0] base, base2, n1;
        base = $urandom;
        n1   = base + 32'd1;
        ws = 0;
        smp_ready = 1'b0;
        hang_n  = n1[15:0];
        hang_en = 1'b1;
        kick(base, 16'd5);
        wait_done(200, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo_done got timeout want done"); end
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || PSEL !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL tmo_status got err=%b busy=%b psel=%b pulses=%0d want 1 0 0 1",
                     err, busy, PSEL, done_cnt - d0);
        end
        checks++;
        if (last_run != TIMEOUT) begin
            errors++;
            $display("FAIL tmo_len got %0d want %0d", last_run, TIMEOUT);
        end
        checks++;
        if (xq.size() != 3) begin errors++; $display("FAIL tmo_nxfer got %0d want 3", xq.size()); end
        checks++;
        if (smp_valid !== 1'b1 || smp_data !== smp_of(base)) begin
            errors++;
            $display("FAIL tmo_head got valid=%b data=%h want 1 %h", smp_valid, smp_data, smp_of(base));
        end
        smp_ready = 1'b1;
        @(posedge PCLK); #1;
        checks++;
        if (smp_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_one_sample got valid=%b want 0", smp_valid);
        end
        hang_en = 1'b0;
        base2 = $urandom;
        kick(base2, 16'd3);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_restart got err=%b busy=%b want 0 1", err, busy);
        end
        wait_done(100, 1'b0, ok);
        drain();
        checks++;
        if (!ok || err !== 1'b0 || sq.size() != 3) begin
            errors++;
            $display("FAIL tmo_recover got ok=%0d err=%b nsmp=%0d want 1 0 3", ok, err, sq.size());
        end
        for (int i = 0; i < sq.size() && i < 3; i++) begin
            checks++;
            if (sq[i] !== smp_of(base2 + 32'(i))) begin
                errors++;
                $display("FAIL tmo_smp[%0d] got %h want %h", i, sq[i], smp_of(base2 + 32'(i)));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ws = 0;
        smp_ready = 1'b0;
        kick($urandom, 16'd4);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (xq.size() >= 3 && PSEL && PENABLE && !PWRITE) begin
                ok = 1'b1;
                break;
            end
            @(posedge PCLK); #1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_reach got timeout want R_ACCESS"); end
        #2;
        PRESET = 1'b1;
        #1;
        checks++;
        if ({PSEL, PENABLE, busy, smp_valid} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid got psel/pen/busy/valid=%b want 0000", {PSEL, PENABLE, busy, smp_valid});
        end
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        smp_ready = 1'b1;
        kick(32'hFFFF_FFFF, 16'd2);
        wait_done(100, 1'b0, ok);
        drain();
        checks++;
        if (!ok || xq.size() != 4) begin
            errors++;
            $display("FAIL wrap_nxfer got ok=%0d xfers=%0d want 1 4", ok, xq.size());
        end
        checks++;
        if (xq.size() < 4 || xq[0].dat !== 32'hFFFF_FFFF || xq[2].dat !== 32'h0) begin
            errors++;
            $display("FAIL wrap_wdata got %h %h want ffffffff 00000000",
                     xq.size() > 0 ? xq[0].dat : 32'hx, xq.size() > 2 ? xq[2].dat : 32'hx);
        end
        checks++;
        if (sq.size() != 2 || sq[0] !== 32'hA5A5_FFFF || sq[1] !== 32'hA5A5_0000) begin
            errors++;
            $display("FAIL wrap_smp got n=%0d want a5a5ffff a5a50000", sq.size());
        end
    endtask

    task automatic test_random();
        bit          ok;
        logic [31:0] base;
        int          c;
        xfer_t       e;
        for (int it = 0; it < 5; it++) begin
            base = $urandom;
            c    = $urandom_range(1, 12);
            ws   = $urandom_range(0, 2);
            kick(base, 16'(c));
            wait_done(1500, 1'b1, ok);
            drain();
            checks++;
            if (!ok || err !== 1'b0 || stab_err != 0) begin
                errors++;
                $display("FAIL rnd%0d_status got ok=%0d err=%b stab=%0d want 1 0 0", it, ok, err, stab_err);
            end
            checks++;
            if (xq.size() != 2 * c || sq.size() != c) begin
                errors++;
                $display("FAIL rnd%0d_count got xfers=%0d smp=%0d want %0d %0d", it, xq.size(), sq.size(), 2 * c, c);
            end
            for (int i = 0; i < xq.size() && i < 2 * c; i++) begin
                e = exp_xfer(base, i);
                checks++;
                if (xq[i].wr !== e.wr || xq[i].addr !== e.addr || xq[i].dat !== e.dat) begin
                    errors++;
                    $display("FAIL rnd%0d_xfer[%0d] got dat=%h want %h", it, i, xq[i].dat, e.dat);
                end
            end
            for (int i = 0; i < sq.size() && i < c; i++) begin
                checks++;
                if (sq[i] !== smp_of(base + 32'(i))) begin
                    errors++;
                    $display("FAIL rnd%0d_smp[%0d] got %h want %h", it, i, sq[i], smp_of(base + 32'(i)));
                end
            end
        end
        ws = 0;
    endtask

    initial begin
        PRESET    = 1'b0;
        start     = 1'b0;
        n_start   = '0;
        n_count   = '0;
        smp_ready = 1'b0;
        ws        = 0;
        hang_en   = 1'b0;
        hang_n    = '0;
        #1;
        PRESET = 1'b1;
        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
